// File: rtl/sisp_pkg.sv
// sisp_pkg: shared widths, FSM state and feature record type for the SISP CCA blocks
package sisp_pkg;
  localparam int SISP_LABEL_W = 7;
  localparam int SISP_X_W     = 9;
  localparam int SISP_Y_W     = 8;
  localparam int SISP_CNT_W   = 16;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_e;

  typedef struct packed {
    logic [SISP_LABEL_W-1:0] label;
    logic [SISP_CNT_W-1:0]   count;
    logic [SISP_X_W-1:0]     xmin;
    logic [SISP_X_W-1:0]     xmax;
    logic [SISP_Y_W-1:0]     ymin;
    logic [SISP_Y_W-1:0]     ymax;
  } rec_t;
endpackage

// File: rtl/cca_feat_entry_upd.sv
// cca_feat_entry_upd: merges one pixel (or an equal-label pair) into a table entry
module cca_feat_entry_upd
  import sisp_pkg::*;
#(
  parameter int X_W   = SISP_X_W,
  parameter int Y_W   = SISP_Y_W,
  parameter int CNT_W = SISP_CNT_W
) (
  input  logic             i_live,
  input  logic             i_two,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [X_W-1:0]   i_xmin,
  input  logic [X_W-1:0]   i_xmax,
  input  logic [Y_W-1:0]   i_ymin,
  input  logic [Y_W-1:0]   i_ymax,
  input  logic [X_W-1:0]   i_px_lo,
  input  logic [X_W-1:0]   i_px_hi,
  input  logic [Y_W-1:0]   i_py,
  output logic [CNT_W-1:0] o_cnt,
  output logic [X_W-1:0]   o_xmin,
  output logic [X_W-1:0]   o_xmax,
  output logic [Y_W-1:0]   o_ymin,
  output logic [Y_W-1:0]   o_ymax
);
  logic [CNT_W-1:0] w_inc;
  logic [CNT_W:0]   w_sum;

  always_comb begin
    w_inc  = i_two ? CNT_W'(2) : CNT_W'(1);
    w_sum  = {1'b0, i_cnt} + {1'b0, w_inc};
    o_cnt  = !i_live ? w_inc : (w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0]);
    o_xmin = (!i_live || i_px_lo < i_xmin) ? i_px_lo : i_xmin;
    o_xmax = (!i_live || i_px_hi > i_xmax) ? i_px_hi : i_xmax;
    o_ymin = (!i_live || i_py < i_ymin) ? i_py : i_ymin;
    o_ymax = (!i_live || i_py > i_ymax) ? i_py : i_ymax;
  end
endmodule

// File: rtl/cca_feature_acc.sv
// cca_feature_acc: per-frame label count/bounding-box table fed by a 2-pixel/cycle CCA stage,
// drained at frame end as one valid/ready record per live label.
module cca_feature_acc
  import sisp_pkg::*;
#(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int LABEL_W = SISP_LABEL_W,
  parameter int X_W     = SISP_X_W,
  parameter int Y_W     = SISP_Y_W,
  parameter int CNT_W   = SISP_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_acc_enable,
  input  logic               i_frame_start,
  input  logic               i_frame_end,
  input  logic               i_pix_valid,
  input  logic [LABEL_W-1:0] i_label_0,
  input  logic [LABEL_W-1:0] i_label_1,
  output logic               o_rd_valid,
  input  logic               i_rd_ready,
  output logic [LABEL_W-1:0] o_rd_label,
  output logic [CNT_W-1:0]   o_rd_count,
  output logic [X_W-1:0]     o_rd_xmin,
  output logic [X_W-1:0]     o_rd_xmax,
  output logic [Y_W-1:0]     o_rd_ymin,
  output logic [Y_W-1:0]     o_rd_ymax,
  output logic               o_frame_done,
  output logic [LABEL_W-1:0] o_num_comp,
  output logic               o_busy
);
  localparam int NL = 1 << LABEL_W;
  localparam logic [X_W-1:0]     LP_X_LAST = X_W'(IMG_W - 2);
  localparam logic [Y_W:0]       LP_H      = (Y_W + 1)'(IMG_H);
  localparam logic [LABEL_W-1:0] LP_MAX    = '1;

  state_e             r_state;
  logic [NL-1:0]      r_live;
  logic [CNT_W-1:0]   r_cnt  [NL];
  logic [X_W-1:0]     r_xmin [NL];
  logic [X_W-1:0]     r_xmax [NL];
  logic [Y_W-1:0]     r_ymin [NL];
  logic [Y_W-1:0]     r_ymax [NL];
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [LABEL_W-1:0] r_idx, r_ncnt, r_num_comp, r_rd_label;
  logic               r_end, r_rd_valid, r_frame_done;
  logic [CNT_W-1:0]   r_rd_count;
  logic [X_W-1:0]     r_rd_xmin, r_rd_xmax;
  logic [Y_W-1:0]     r_rd_ymin, r_rd_ymax;

  logic [X_W-1:0]   w_x, w_x1, w_px_hi0;
  logic [Y_W-1:0]   w_y;
  logic             w_acc, w_eq, w_we0, w_we1, w_live0, w_live1, w_go, w_fin;
  logic [CNT_W-1:0] w_cnt0, w_cnt1;
  logic [X_W-1:0]   w_xmin0, w_xmax0, w_xmin1, w_xmax1;
  logic [Y_W-1:0]   w_ymin0, w_ymax0, w_ymin1, w_ymax1;

  // a pair on the frame_start cycle sees origin coordinates and an empty table
  always_comb begin
    w_x      = i_frame_start ? '0 : r_x;
    w_y      = i_frame_start ? '0 : r_y;
    w_x1     = w_x + X_W'(1);
    w_acc    = (i_frame_start || r_state == S_ACCUM) && i_acc_enable && i_pix_valid && ({1'b0, w_y} < LP_H);
    w_eq     = i_label_0 == i_label_1;
    w_we0    = w_acc && (i_label_0 != '0);
    w_we1    = w_acc && (i_label_1 != '0) && !w_eq;
    w_live0  = !i_frame_start && r_live[i_label_0];
    w_live1  = !i_frame_start && r_live[i_label_1];
    w_px_hi0 = w_eq ? w_x1 : w_x;
    w_go     = (r_state == S_DRAIN) && (!r_rd_valid || i_rd_ready);
    w_fin    = r_end || (r_idx == LP_MAX && !r_live[r_idx]);
  end

  cca_feat_entry_upd #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)) u_upd0 (
    .i_live(w_live0), .i_two(w_eq), .i_cnt(r_cnt[i_label_0]),
    .i_xmin(r_xmin[i_label_0]), .i_xmax(r_xmax[i_label_0]),
    .i_ymin(r_ymin[i_label_0]), .i_ymax(r_ymax[i_label_0]),
    .i_px_lo(w_x), .i_px_hi(w_px_hi0), .i_py(w_y),
    .o_cnt(w_cnt0), .o_xmin(w_xmin0), .o_xmax(w_xmax0), .o_ymin(w_ymin0), .o_ymax(w_ymax0)
  );

  cca_feat_entry_upd #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)) u_upd1 (
    .i_live(w_live1), .i_two(1'b0), .i_cnt(r_cnt[i_label_1]),
    .i_xmin(r_xmin[i_label_1]), .i_xmax(r_xmax[i_label_1]),
    .i_ymin(r_ymin[i_label_1]), .i_ymax(r_ymax[i_label_1]),
    .i_px_lo(w_x1), .i_px_hi(w_x1), .i_py(w_y),
    .o_cnt(w_cnt1), .o_xmin(w_xmin1), .o_xmax(w_xmax1), .o_ymin(w_ymin1), .o_ymax(w_ymax1)
  );

  // entry payload is only meaningful behind its live bit, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_we0) begin
      r_cnt[i_label_0]  <= w_cnt0;
      r_xmin[i_label_0] <= w_xmin0;
      r_xmax[i_label_0] <= w_xmax0;
      r_ymin[i_label_0] <= w_ymin0;
      r_ymax[i_label_0] <= w_ymax0;
    end
    if (w_we1) begin
      r_cnt[i_label_1]  <= w_cnt1;
      r_xmin[i_label_1] <= w_xmin1;
      r_xmax[i_label_1] <= w_xmax1;
      r_ymin[i_label_1] <= w_ymin1;
      r_ymax[i_label_1] <= w_ymax1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_live       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_idx        <= '0;
      r_ncnt       <= '0;
      r_num_comp   <= '0;
      r_end        <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_rd_label   <= '0;
      r_rd_count   <= '0;
      r_rd_xmin    <= '0;
      r_rd_xmax    <= '0;
      r_rd_ymin    <= '0;
      r_rd_ymax    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_acc) begin
        r_x <= (w_x == LP_X_LAST) ? '0 : w_x + X_W'(2);
        r_y <= (w_x == LP_X_LAST) ? w_y + Y_W'(1) : w_y;
      end else if (i_frame_start) begin
        r_x <= '0;
        r_y <= '0;
      end
      if (i_frame_start) r_live <= '0;
      if (w_we0) r_live[i_label_0] <= 1'b1;
      if (w_we1) r_live[i_label_1] <= 1'b1;
      if (i_frame_start) begin
        r_state    <= S_ACCUM;
        r_rd_valid <= 1'b0;
      end else begin
        case (r_state)
          S_ACCUM: if (i_frame_end) begin
            r_state <= S_DRAIN;
            r_idx   <= LABEL_W'(1);
            r_ncnt  <= '0;
            r_end   <= 1'b0;
          end
          S_DRAIN: if (w_go) begin
            if (w_fin) begin
              r_state      <= S_IDLE;
              r_rd_valid   <= 1'b0;
              r_frame_done <= 1'b1;
              r_num_comp   <= r_ncnt;
            end else begin
              r_rd_valid <= r_live[r_idx];
              if (r_live[r_idx]) begin
                r_rd_label <= r_idx;
                r_rd_count <= r_cnt[r_idx];
                r_rd_xmin  <= r_xmin[r_idx];
                r_rd_xmax  <= r_xmax[r_idx];
                r_rd_ymin  <= r_ymin[r_idx];
                r_rd_ymax  <= r_ymax[r_idx];
                r_ncnt     <= r_ncnt + LABEL_W'(1);
              end
              if (r_idx == LP_MAX) r_end <= 1'b1;
              else r_idx <= r_idx + LABEL_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_rd_valid   = r_rd_valid;
  assign o_rd_label   = r_rd_label;
  assign o_rd_count   = r_rd_count;
  assign o_rd_xmin    = r_rd_xmin;
  assign o_rd_xmax    = r_rd_xmax;
  assign o_rd_ymin    = r_rd_ymin;
  assign o_rd_ymax    = r_rd_ymax;
  assign o_frame_done = r_frame_done;
  assign o_num_comp   = r_num_comp;
  assign o_busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_cca_feature_acc.sv
// tb_cca_feature_acc: scenario tasks with a record scoreboard for cca_feature_acc
module tb_cca_feature_acc;
  import sisp_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       acc_en = 1'b1, fs = 1'b0, fe = 1'b0, pv = 1'b0, rdy = 1'b0;
  logic [6:0] l0 = '0, l1 = '0;
  logic       o_rd_valid, o_frame_done, o_busy;
  logic [6:0] o_rd_label, o_num_comp;
  logic [15:0] o_rd_count;
  logic [8:0] o_rd_xmin, o_rd_xmax;
  logic [7:0] o_rd_ymin, o_rd_ymax;

  int   n_pass = 0, n_total = 0;
  rec_t sb[$];

  cca_feature_acc dut (
    .clk(clk), .rst_n(rst_n), .i_acc_enable(acc_en), .i_frame_start(fs), .i_frame_end(fe),
    .i_pix_valid(pv), .i_label_0(l0), .i_label_1(l1), .o_rd_valid(o_rd_valid), .i_rd_ready(rdy),
    .o_rd_label(o_rd_label), .o_rd_count(o_rd_count), .o_rd_xmin(o_rd_xmin), .o_rd_xmax(o_rd_xmax),
    .o_rd_ymin(o_rd_ymin), .o_rd_ymax(o_rd_ymax), .o_frame_done(o_frame_done),
    .o_num_comp(o_num_comp), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(input int lb, cnt, xmn, xmx, ymn, ymx);
    return '{SISP_LABEL_W'(lb), SISP_CNT_W'(cnt), SISP_X_W'(xmn), SISP_X_W'(xmx), SISP_Y_W'(ymn), SISP_Y_W'(ymx)};
  endfunction

  function automatic rec_t act();
    return {o_rd_label, o_rd_count, o_rd_xmin, o_rd_xmax, o_rd_ymin, o_rd_ymax};
  endfunction

  task automatic drive(input logic f_s, f_e, p_v, input logic [6:0] a, b, input logic en = 1'b1);
    @(negedge clk);
    fs = f_s; fe = f_e; pv = p_v; l0 = a; l1 = b; acc_en = en;
  endtask

  task automatic pairs(input int n, input logic [6:0] a, b);
    repeat (n) drive(1'b0, 1'b0, 1'b1, a, b);
  endtask

  // pops the scoreboard on each handshake; optionally toggles ready, checks tail and back-to-back timing
  task automatic run_drain(input bit toggle, input int exp_n, input bit chk_tail, input bit chk_b2b);
    int   n_acc = 0, last = -10;
    bit   stalled = 0, done = 0;
    rec_t held, e;
    rdy = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      fs = 1'b0; fe = 1'b0; pv = 1'b0;
      if (o_frame_done) begin
        done = 1;
        n_total++;
        if (o_num_comp !== 7'(exp_n)) $display("FAIL num_comp got %0d want %0d", o_num_comp, exp_n); else n_pass++;
        n_total++;
        if (n_acc != exp_n || sb.size() != 0) $display("FAIL record_count got %0d left %0d want %0d", n_acc, sb.size(), exp_n); else n_pass++;
        n_total++;
        if (o_busy !== 1'b0) $display("FAIL busy_after_done got %b want 0", o_busy); else n_pass++;
        if (chk_tail) begin
          n_total++;
          if (i != last + 1) $display("FAIL done_latency got cycle %0d want %0d", i, last + 1); else n_pass++;
        end
      end else begin
        if (stalled) begin
          n_total++;
          if (act() !== held) $display("FAIL stall_hold got %h want %h", act(), held); else n_pass++;
        end
        rdy = toggle ? ~rdy : 1'b1;
        stalled = 0;
        if (o_rd_valid && rdy) begin
          n_total++;
          if (sb.size() == 0) $display("FAIL extra_record got %h want none", act());
          else begin
            e = sb.pop_front();
            if (act() !== e) $display("FAIL record got %h want %h", act(), e); else n_pass++;
          end
          if (chk_b2b && n_acc > 0) begin
            n_total++;
            if (i != last + 1) $display("FAIL back_to_back got cycle %0d want %0d", i, last + 1); else n_pass++;
          end
          n_acc++;
          last = i;
        end else if (o_rd_valid) begin
          stalled = 1;
          held = act();
        end
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL drain_timeout got no frame_done want frame_done within 400 cycles");
    end
    rdy = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (o_rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", o_rd_valid); else n_pass++;
    n_total++; if (act() !== '0) $display("FAIL reset_rd_fields got %h want 0", act()); else n_pass++;
    n_total++; if (o_frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", o_frame_done); else n_pass++;
    n_total++; if (o_num_comp !== '0) $display("FAIL reset_num_comp got %0d want 0", o_num_comp); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_label();
    drive(1, 0, 1, 0, 0);
    pairs(484, 0, 0);
    n_total++; if (o_busy !== 1'b1) $display("FAIL busy_accum got %b want 1", o_busy); else n_pass++;
    drive(0, 0, 1, 5, 5);
    drive(0, 1, 0, 0, 0);
    sb.push_back(mk(5, 2, 10, 11, 3, 3));
    run_drain(0, 1, 0, 0);
  endtask

  task automatic test_two_labels();
    drive(1, 0, 1, 3, 7);
    drive(0, 0, 1, 50, 50, 1'b0);
    pairs(161, 0, 0);
    drive(0, 0, 1, 3, 0);
    drive(0, 1, 0, 0, 0);
    sb.push_back(mk(3, 2, 0, 4, 0, 1));
    sb.push_back(mk(7, 1, 1, 1, 0, 0));
    run_drain(0, 2, 0, 0);
  endtask

  task automatic test_wrap_and_end_pair();
    drive(1, 0, 1, 9, 0);
    pairs(158, 0, 0);
    drive(0, 0, 1, 0, 9);
    drive(0, 0, 1, 10, 0);
    drive(0, 1, 1, 11, 11);
    sb.push_back(mk(9, 2, 0, 319, 0, 0));
    sb.push_back(mk(10, 1, 0, 0, 1, 1));
    sb.push_back(mk(11, 2, 2, 3, 1, 1));
    run_drain(0, 3, 0, 0);
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 1, 1, 2);
    drive(0, 1, 1, 3, 0);
    sb.push_back(mk(1, 1, 0, 0, 0, 0));
    sb.push_back(mk(2, 1, 1, 1, 0, 0));
    sb.push_back(mk(3, 1, 2, 2, 0, 0));
    run_drain(0, 3, 0, 1);
  endtask

  task automatic test_backpressure();
    drive(1, 0, 1, 125, 126);
    drive(0, 0, 1, 127, 0);
    drive(0, 1, 0, 0, 0);
    sb.push_back(mk(125, 1, 0, 0, 0, 0));
    sb.push_back(mk(126, 1, 1, 1, 0, 0));
    sb.push_back(mk(127, 1, 2, 2, 0, 0));
    run_drain(1, 3, 1, 0);
  endtask

  task automatic test_abort();
    bit   got4 = 0, hit = 0;
    rec_t e;
    drive(1, 0, 1, 4, 5);
    drive(0, 1, 0, 0, 0);
    sb.push_back(mk(4, 1, 0, 0, 0, 0));
    sb.push_back(mk(5, 1, 1, 1, 0, 0));
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      fe = 1'b0;
      if (o_rd_valid && sb.size() != 0) begin
        e = sb.pop_front();
        n_total++;
        if (act() !== e) $display("FAIL abort_record got %h want %h", act(), e); else n_pass++;
        if (!got4) begin
          rdy = 1'b1;
          got4 = 1;
        end else begin
          rdy = 1'b0; fs = 1'b1; pv = 1'b1; l0 = 7'd8; l1 = 7'd0;
          hit = 1;
        end
      end
    end
    if (!hit) begin
      n_total++;
      $display("FAIL abort_timeout got no second record want record 5");
    end
    @(negedge clk);
    fs = 1'b0; pv = 1'b0;
    n_total++; if (o_rd_valid !== 1'b0) $display("FAIL abort_rd_valid got %b want 0", o_rd_valid); else n_pass++;
    n_total++; if (o_frame_done !== 1'b0) $display("FAIL abort_frame_done got %b want 0", o_frame_done); else n_pass++;
    n_total++; if (o_busy !== 1'b1) $display("FAIL abort_busy got %b want 1", o_busy); else n_pass++;
    drive(0, 1, 0, 0, 0);
    sb.push_back(mk(8, 1, 0, 0, 0, 0));
    run_drain(0, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 1, 30, 0);
    drive(0, 0, 1, 31, 31);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (o_busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", o_busy); else n_pass++;
    n_total++; if (o_num_comp !== '0) $display("FAIL midreset_num_comp got %0d want 0", o_num_comp); else n_pass++;
    n_total++; if (o_rd_valid !== 1'b0 || act() !== '0) $display("FAIL midreset_rd got %b/%h want 0/0", o_rd_valid, act()); else n_pass++;
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_total++; if (o_busy !== 1'b0) $display("FAIL idle_frame_end got busy %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_saturation_last_line();
    drive(1, 0, 1, 1, 1);
    pairs(38398, 1, 1);
    drive(0, 0, 1, 20, 0);
    pairs(5, 21, 21);
    drive(0, 1, 1, 22, 22);
    sb.push_back(mk(1, 65535, 0, 319, 0, 239));
    sb.push_back(mk(20, 1, 318, 318, 239, 239));
    run_drain(0, 2, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single_label();
    test_two_labels();
    test_wrap_and_end_pair();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_saturation_last_line();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
